seq_detect_ctrl: RTL and testbench

- Test/stimulus sequencer for the one-hot four-in-a-row sequence detector (z high after four consecutive equal bits on w).
- Latches a bit pattern and length, resets the detector, then plays the pattern serially on w, LSB first, one bit per clock.
- Samples the detector's z output, counts high cycles, records the bit index of the first detection, and signals completion with a one-cycle done pulse.
- Sits between board switches/keys and the detector instance.

---
 rtl/seq_detect_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Stimulus sequencer for the four-in-a-row detector.
// Plays a latched pattern on w and scores the detector's z.
module seq_detect_ctrl #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [4:0]       len_in,
  input  logic             z,
  output logic             w,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [4:0]       first_idx,
  output logic             found
);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_CLR   = 5'b00010;
  localparam logic [4:0] S_RUN   = 5'b00100;
  localparam logic [4:0] S_DRAIN = 5'b01000;
  localparam logic [4:0] S_DONE  = 5'b10000;

  localparam logic [4:0]       PW   = 5'(PAT_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [4:0]       state;
  logic [4:0]       state_nx;
  logic [PAT_W-1:0] pat_q;
  logic [4:0]       len_q;
  logic [4:0]       len_cl;
  logic [4:0]       idx;
  logic [PAT_W-1:0] sh;
  logic             st_idle;
  logic             st_clr;
  logic             st_run;
  logic             st_drain;
  logic             st_done;
  logic             last_bit;
  logic             hit;

  assign st_idle  = state[0];
  assign st_clr   = state[1];
  assign st_run   = state[2];
  assign st_drain = state[3];
  assign st_done  = state[4];

  assign last_bit = (idx == len_q - 5'd1);
  assign hit      = (st_run | st_drain) & z;

  assign busy      = ~st_idle;
  assign done      = st_done;
  assign det_rst_n = reset & ~st_clr;

  // A zero or oversized length plays the whole pattern.
  always_comb begin
    len_cl = len_in;
    if (len_in == 5'd0 || len_in > PW)
      len_cl = PW;
  end

  // Serial bit: current index in RUN, last bit held in DRAIN.
  always_comb begin
    sh = '0;
    w  = 1'b0;
    if (st_run) begin
      sh = pat_q >> idx;
      w  = sh[0];
    end else if (st_drain) begin
      sh = pat_q >> (len_q - 5'd1);
      w  = sh[0];
    end
  end

  // Next-state decode over the one-hot state vector.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      st_idle:  if (start) state_nx = S_CLR;
      st_clr:   state_nx = S_RUN;
      st_run:   if (last_bit) state_nx = S_DRAIN;
      st_drain: state_nx = S_DONE;
      st_done:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Capture pattern and clamped length when a run is accepted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
    end else if (st_idle && start) begin
      pat_q <= pat_in;
      len_q <= len_cl;
    end
  end

  // Bit index: cleared in CLR, advanced through RUN, held after.
  always_ff @(posedge clock) begin
    if (!reset)
      idx <= '0;
    else if (st_clr)
      idx <= '0;
    else if (st_run)
      idx <= idx + 5'd1;
  end

  // Score z: saturating hit count and first detection index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else if (st_clr) begin
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else if (hit) begin
      if (match_cnt != CMAX)
        match_cnt <= match_cnt + 1'b1;
      if (!found) begin
        first_idx <= idx - 5'd1;
        found     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl.
// A behavioural run-length detector model supplies z.
module tb_seq_detect_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pat_in;
  logic [4:0]  len_in;
  logic        z;

  logic        w;
  logic        det_rst_n;
  logic        busy;
  logic        done;
  logic [4:0]  match_cnt;
  logic [4:0]  first_idx;
  logic        found;

  logic        w3;
  logic        det_rst_n3;
  logic        busy3;
  logic        done3;
  logic [2:0]  match_cnt3;
  logic [4:0]  first_idx3;
  logic        found3;

  int n_chk;
  int n_fail;

  seq_detect_ctrl #(.PAT_W(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .pat_in(pat_in), .len_in(len_in), .z(z),
    .w(w), .det_rst_n(det_rst_n), .busy(busy), .done(done),
    .match_cnt(match_cnt), .first_idx(first_idx), .found(found)
  );

  seq_detect_ctrl #(.PAT_W(16), .CNT_W(3)) dut3 (
    .clock(clock), .reset(reset), .start(start),
    .pat_in(pat_in), .len_in(len_in), .z(z),
    .w(w3), .det_rst_n(det_rst_n3), .busy(busy3), .done(done3),
    .match_cnt(match_cnt3), .first_idx(first_idx3), .found(found3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Detector model: z after four equal bits in a row.
  logic [2:0] run_len;
  logic       last_w;
  always_ff @(posedge clock) begin
    if (!det_rst_n) begin
      run_len <= 3'd0;
      last_w  <= 1'b0;
    end else if (run_len == 3'd0 || w != last_w) begin
      run_len <= 3'd1;
      last_w  <= w;
    end else if (run_len != 3'd4) begin
      run_len <= run_len + 3'd1;
    end
  end
  assign z = (run_len == 3'd4);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    int          eff;
    int          dcyc;
    int          cnt;
    int          cnt3;
    int          first;
    int          fnd;
    bit          tog;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int bad_busy;
    int bad_done;
    int bad_w;
    logic exp_w;
    bad_busy = 0;
    bad_done = 0;
    bad_w    = 0;
    @(negedge clock);
    start  = 1'b1;
    pat_in = v.pat;
    len_in = v.len;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= v.dcyc + 3; c++) begin
      @(negedge clock);
      if (busy !== (c <= v.dcyc)) bad_busy++;
      if (done !== (c == v.dcyc)) bad_done++;
      if (c >= 2 && c <= v.eff + 1)
        exp_w = v.pat[c-2];
      else if (c == v.eff + 2)
        exp_w = v.pat[v.eff-1];
      else
        exp_w = 1'b0;
      if (w !== exp_w) bad_w++;
      if (v.tog && c == 5) start = 1'b1;
      if (v.tog && c == 7) start = 1'b0;
    end
    chk("busy_seq", bad_busy, 0);
    chk("done_seq", bad_done, 0);
    chk("w_seq", bad_w, 0);
    chk("match_cnt", int'(match_cnt), v.cnt);
    chk("match_cnt_w3", int'(match_cnt3), v.cnt3);
    chk("first_idx", int'(first_idx), v.first);
    chk("found", int'(found), v.fnd);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{16'h000F, 5'd8,  8, 11,  2, 2, 3, 1, 1'b0};
    vecs[1] = '{16'h5555, 5'd16, 16, 19, 0, 0, 0, 0, 1'b0};
    vecs[2] = '{16'hFFFF, 5'd16, 16, 19, 13, 7, 3, 1, 1'b0};
    vecs[3] = '{16'hFFFF, 5'd0,  16, 19, 13, 7, 3, 1, 1'b1};
    vecs[4] = '{16'hFFFF, 5'd20, 16, 19, 13, 7, 3, 1, 1'b0};
    vecs[5] = '{16'h000F, 5'd8,  8, 11,  2, 2, 3, 1, 1'b1};

    reset  = 1'b0;
    start  = 1'b0;
    pat_in = '0;
    len_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_w", int'(w), 0);
    chk("rst_match", int'(match_cnt), 0);
    chk("rst_first", int'(first_idx), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_det_rst_n", int'(det_rst_n), 0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("idle_det_rst_n", int'(det_rst_n), 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort in the fifth RUN cycle.
    begin
      int dseen;
      dseen = 0;
      @(negedge clock);
      start  = 1'b1;
      pat_in = 16'h000F;
      len_in = 5'd8;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (6) @(negedge clock);
      chk("abort_busy_before", int'(busy), 1);
      reset = 1'b0;
      #1 chk("abort_det_rst_n", int'(det_rst_n), 0);
      @(posedge clock);
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_match", int'(match_cnt), 0);
      chk("abort_found", int'(found), 0);
      chk("abort_w", int'(w), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 14; c++) begin
        @(negedge clock);
        if (done) dseen++;
      end
      chk("abort_no_done", dseen, 0);
    end

    run_vec(vecs[5]);

    // Start held high: back-to-back runs via one IDLE cycle.
    begin
      int bad;
      bad = 0;
      @(negedge clock);
      start  = 1'b1;
      pat_in = 16'h000F;
      len_in = 5'd8;
      @(posedge clock);
      for (int c = 1; c <= 26; c++) begin
        @(negedge clock);
        if (done !== (c == 11 || c == 23)) bad++;
        if (busy !== (c != 12 && c <= 23)) bad++;
        if (c == 13) start = 1'b0;
      end
      chk("held_start_seq", bad, 0);
      chk("held_match", int'(match_cnt), 2);
      chk("held_first", int'(first_idx), 3);
      chk("held_found", int'(found), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
